// File: rtl/rs_drv_pkg.sv
// Shared definitions for the RS cell excitation driver: FSM encoding and
// default sizing constants.
package rs_drv_pkg;

  localparam int RSDRV_WIDTH_DEF     = 8;
  localparam int RSDRV_MAX_RETRY_DEF = 3;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_DRIVE_ENC  = 3'd1;
  localparam logic [2:0] ST_SETTLE_ENC = 3'd2;
  localparam logic [2:0] ST_CHECK_ENC  = 3'd3;
  localparam logic [2:0] ST_REPORT_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_DRIVE  = ST_DRIVE_ENC,
    ST_SETTLE = ST_SETTLE_ENC,
    ST_CHECK  = ST_CHECK_ENC,
    ST_REPORT = ST_REPORT_ENC
  } rs_state_e;

endpackage

// File: rtl/rs_exc_encode.sv
// Set/reset excitation encoder. Minimal mode only touches bits that differ
// from the current cell value; full mode forces every bit toward the target.
module rs_exc_encode
  import rs_drv_pkg::*;
#(
  parameter int WIDTH = RSDRV_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] target_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             force_all_i,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] r_o
);

  // Both branches derive s and r from complementary target terms, so a bit
  // can never see S and R together.
  always_comb begin
    if (force_all_i) begin
      s_o = target_i;
      r_o = ~target_i;
    end else begin
      s_o = target_i & ~q_i;
      r_o = ~target_i & q_i;
    end
  end

endmodule

// File: rtl/rs_excitation_driver.sv
// Drives a bank of external RS cells to a requested word and verifies the
// readback. Optional retry with full forcing excitation: define RSDRV_RETRY_EN.
//
// state  | meaning
// IDLE   | ready for a target word
// DRIVE  | one cycle of set/reset excitation
// SETTLE | excitation removed, cells settle
// CHECK  | compare q/qbar readback against target
// REPORT | one-cycle done or err pulse
module rs_excitation_driver
  import rs_drv_pkg::*;
#(
  parameter int WIDTH     = RSDRV_WIDTH_DEF,
  parameter int MAX_RETRY = RSDRV_MAX_RETRY_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] qbar_in,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask
);

  rs_state_e        state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] s_q, s_d, r_q, r_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             done_q, done_d, err_q, err_d;

  logic [WIDTH-1:0] enc_target, enc_s, enc_r, fail_bits;
  logic             enc_force, retry_left;

`ifdef RSDRV_RETRY_EN
  localparam int CNT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [CNT_W-1:0] attempt_q, attempt_d;

  assign retry_left = attempt_q < CNT_W'(MAX_RETRY);
  assign enc_force  = (state_q == ST_CHECK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) attempt_q <= '0;
    else          attempt_q <= attempt_d;
  end
`else
  logic unused_max_retry;

  assign unused_max_retry = (MAX_RETRY != 0);
  assign retry_left       = 1'b0;
  assign enc_force        = 1'b0;
`endif

  // The first drive encodes straight from the offered word and the live q_in
  // at the handshake edge, so it lands in DRIVE without an extra cycle.
  assign enc_target = (state_q == ST_IDLE) ? tgt_data : target_q;

  rs_exc_encode #(.WIDTH(WIDTH)) u_encode (
    .target_i    (enc_target),
    .q_i         (q_in),
    .force_all_i (enc_force),
    .s_o         (enc_s),
    .r_o         (enc_r)
  );

  assign fail_bits = (q_in ^ target_q) | (qbar_in ^ ~target_q) | ~(q_in ^ qbar_in);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    mask_d   = mask_q;
    s_d      = '0;
    r_d      = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
`ifdef RSDRV_RETRY_EN
    attempt_d = attempt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (tgt_valid) begin
          state_d  = ST_DRIVE;
          target_d = tgt_data;
          mask_d   = '0;
          s_d      = enc_s;
          r_d      = enc_r;
`ifdef RSDRV_RETRY_EN
          attempt_d = '0;
`endif
        end
      end
      ST_DRIVE:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_CHECK;
      ST_CHECK: begin
        if (fail_bits == '0) begin
          state_d = ST_REPORT;
          done_d  = 1'b1;
        end else if (retry_left) begin
          state_d = ST_DRIVE;
          s_d     = enc_s;
          r_d     = enc_r;
`ifdef RSDRV_RETRY_EN
          attempt_d = attempt_q + 1'b1;
`endif
        end else begin
          state_d = ST_REPORT;
          err_d   = 1'b1;
          mask_d  = fail_bits;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      s_q      <= '0;
      r_q      <= '0;
      mask_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      s_q      <= s_d;
      r_q      <= r_d;
      mask_q   <= mask_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign tgt_ready = (state_q == ST_IDLE);
  assign s_out     = s_q;
  assign r_out     = r_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_mask  = mask_q;

endmodule

// File: tb/tb_rs_excitation_driver.sv
// Self-checking bench for rs_excitation_driver with behavioural RS cells and
// a scoreboard of expected done/err outcomes.
module tb_rs_excitation_driver;

  localparam int W = 8;
`ifdef RSDRV_RETRY_EN
  localparam int STUCK_DRIVES = 4;
  localparam int STUCK_LAT    = 13;
`else
  localparam int STUCK_DRIVES = 1;
  localparam int STUCK_LAT    = 4;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         tgt_valid = 1'b0;
  logic         tgt_ready, done, err;
  logic [W-1:0] tgt_data = '0;
  logic [W-1:0] s_out, r_out, q_in, qbar_in, err_mask;

  logic [W-1:0] cell_q = '0;
  logic [W-1:0] stuck0 = '0;
  logic [W-1:0] preset_val = '0;
  logic         preset_en = 1'b0;

  always #5 clk = ~clk;

  rs_excitation_driver #(.WIDTH(W), .MAX_RETRY(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_data  (tgt_data),
    .s_out     (s_out),
    .r_out     (r_out),
    .q_in      (q_in),
    .qbar_in   (qbar_in),
    .done      (done),
    .err       (err),
    .err_mask  (err_mask)
  );

  // Behavioural RS cells; stuck0 bits always read back as 0.
  always @(posedge clk) begin
    if (preset_en) cell_q <= preset_val;
    else           cell_q <= (cell_q | s_out) & ~r_out;
  end
  assign q_in    = cell_q & ~stuck0;
  assign qbar_in = ~q_in;

  typedef struct {
    string        tag;
    logic         is_err;
    logic [W-1:0] mask;
    int           lat;
    int           drives;
    logic [W-1:0] first_s;
    logic [W-1:0] first_r;
    logic [W-1:0] final_q;
  } exp_t;

  exp_t exp_q[$];

  int n_run = 0, n_fail = 0;
  int cyc = 0, hs_cyc = -1, drive_cnt = 0, viol_cnt = 0, unexp_cnt = 0;
  logic [W-1:0] first_s = '0, first_r = '0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: excitation bookkeeping and scoreboard pop on done/err.
  always @(negedge clk) begin : mon
    exp_t e;
    if ((s_out & r_out) != '0) viol_cnt++;
    if ((s_out | r_out) != '0) drive_cnt++;
    if (cyc == hs_cyc) begin
      first_s = s_out;
      first_r = r_out;
    end
    if (reset_n && tgt_valid && tgt_ready) begin
      hs_cyc    = cyc + 1;
      drive_cnt = 0;
    end
    if (done && err) unexp_cnt++;
    if (done || err) begin
      if (exp_q.size() == 0) begin
        unexp_cnt++;
      end else begin
        e = exp_q.pop_front();
        chk_val({e.tag, "_done"},    done, !e.is_err);
        chk_val({e.tag, "_err"},     err, e.is_err);
        chk_val({e.tag, "_errmask"}, err_mask, e.mask);
        chk_val({e.tag, "_latency"}, cyc + 1 - hs_cyc, e.lat);
        chk_val({e.tag, "_drives"},  drive_cnt, e.drives);
        chk_val({e.tag, "_first_s"}, first_s, e.first_s);
        chk_val({e.tag, "_first_r"}, first_r, e.first_r);
        chk_val({e.tag, "_cells"},   q_in, e.final_q);
      end
    end
  end

  task automatic push_exp(input string tag, input logic [W-1:0] cells, input logic [W-1:0] tgt,
                          input logic [W-1:0] stuck, input logic is_err, input logic [W-1:0] mask,
                          input int lat, input int drives);
    exp_t e;
    e.tag     = tag;
    e.is_err  = is_err;
    e.mask    = mask;
    e.lat     = lat;
    e.drives  = drives;
    e.first_s = tgt & ~cells;
    e.first_r = ~tgt & cells;
    e.final_q = tgt & ~stuck;
    exp_q.push_back(e);
  endtask

  task automatic preset_cells(input logic [W-1:0] val, input logic [W-1:0] stuck);
    stuck0     = stuck;
    preset_val = val;
    preset_en  = 1'b1;
    @(posedge clk); #1;
    preset_en  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk_val({tag, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input string tag, input logic [W-1:0] preset, input logic [W-1:0] tgt,
                         input logic [W-1:0] stuck, input logic is_err, input logic [W-1:0] mask,
                         input int lat, input int drives);
    preset_cells(preset, stuck);
    push_exp(tag, preset & ~stuck, tgt, stuck, is_err, mask, lat, drives);
    chk_val({tag, "_ready"}, tgt_ready, 1);
    tgt_data  = tgt;
    tgt_valid = 1'b1;
    @(posedge clk); #1;
    tgt_valid = 1'b0;
    tgt_data  = ~tgt;
    chk_val({tag, "_busy"}, tgt_ready, 0);
    chk_val({tag, "_mask_clr"}, err_mask, 0);
    wait_drain(tag);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] p, t;
    repeat (3) @(posedge clk);
    #1;
    chk_val("rst_s_out",    s_out, 0);
    chk_val("rst_r_out",    r_out, 0);
    chk_val("rst_done",     done, 0);
    chk_val("rst_err",      err, 0);
    chk_val("rst_err_mask", err_mask, 0);
    chk_val("rst_ready",    tgt_ready, 1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_txn("a5",     8'h00, 8'hA5, 8'h00, 1'b0, 8'h00, 4, 1);
    run_txn("f0_0f",  8'hF0, 8'h0F, 8'h00, 1'b0, 8'h00, 4, 1);
    run_txn("same",   8'h3C, 8'h3C, 8'h00, 1'b0, 8'h00, 4, 0);
    run_txn("stuck3", 8'h00, 8'hFF, 8'h08, 1'b1, 8'h08, STUCK_LAT, STUCK_DRIVES);
    repeat (2) @(posedge clk);
    #1;
    chk_val("err_mask_hold", err_mask, 8'h08);
    run_txn("after_err", 8'h55, 8'hAA, 8'h00, 1'b0, 8'h00, 4, 1);

    for (int i = 0; i < 4; i++) begin
      p = 8'($urandom);
      t = 8'($urandom);
      run_txn("rnd", p, t, 8'h00, 1'b0, 8'h00, 4, (p != t) ? 1 : 0);
    end

    // Reset in SETTLE aborts silently.
    preset_cells(8'h00, 8'h00);
    tgt_data  = 8'h81;
    tgt_valid = 1'b1;
    @(posedge clk); #1;
    tgt_valid = 1'b0;
    chk_val("abort_drive_s", s_out, 8'h81);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk_val("abort_s_out",    s_out, 0);
    chk_val("abort_r_out",    r_out, 0);
    chk_val("abort_done",     done, 0);
    chk_val("abort_err",      err, 0);
    chk_val("abort_err_mask", err_mask, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk_val("abort_ready", tgt_ready, 1);
    run_txn("after_rst", 8'h81, 8'h3C, 8'h00, 1'b0, 8'h00, 4, 1);

    // tgt_valid held with changing data: only IDLE handshakes count.
    preset_cells(8'h00, 8'h00);
    push_exp("hold1", 8'h00, 8'h5A, 8'h00, 1'b0, 8'h00, 4, 1);
    tgt_data  = 8'h5A;
    tgt_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      tgt_data = 8'($urandom);
      @(posedge clk); #1;
    end
    push_exp("hold2", 8'h5A, 8'hC3, 8'h00, 1'b0, 8'h00, 4, 1);
    tgt_data = 8'hC3;
    repeat (2) @(posedge clk);
    #1;
    tgt_valid = 1'b0;
    tgt_data  = 8'h00;
    wait_drain("hold");

    chk_val("s_and_r_cycles",    viol_cnt, 0);
    chk_val("unexpected_pulses", unexp_cnt, 0);
    chk_val("scoreboard_empty",  exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
